// File: rtl/ucsbece154b_icache_if.sv
// Fetch-side and refill-side signals of the instruction cache.
// slave: the cache; master: fetch stage plus instruction memory.
interface ucsbece154b_icache_if;
    logic        read_enable;
    logic [31:0] read_address;
    logic [31:0] instruction;
    logic        ready;
    logic [31:0] mem_read_address;
    logic        mem_read_request;
    logic [31:0] mem_data_in;
    logic        mem_data_ready;

    modport slave (
        input  read_enable,
        input  read_address,
        input  mem_data_in,
        input  mem_data_ready,
        output instruction,
        output ready,
        output mem_read_address,
        output mem_read_request
    );

    modport master (
        output read_enable,
        output read_address,
        output mem_data_in,
        output mem_data_ready,
        input  instruction,
        input  ready,
        input  mem_read_address,
        input  mem_read_request
    );
endinterface

// File: rtl/ucsbece154b_icache.sv
// 2-way set-associative read-only instruction cache with combinational hits
// and a single-block burst refill on miss.
module ucsbece154b_icache #(
    parameter int unsigned NUM_SETS    = 8,
    parameter int unsigned BLOCK_WORDS = 4
) (
    input logic                  clk,
    input logic                  reset,
    ucsbece154b_icache_if.slave  bus
);

    localparam int unsigned OffW = $clog2(BLOCK_WORDS);
    localparam int unsigned IdxW = $clog2(NUM_SETS);
    localparam int unsigned TagW = 32 - OffW - IdxW - 2;
    localparam logic [31:0] Nop  = 32'h0000_0013;

    typedef enum logic [1:0] {StIdle, StReq, StFill} state_e;

    state_e              state_q;
    logic [NUM_SETS-1:0] valid_q [2];
    logic [TagW-1:0]     tag_q   [2][NUM_SETS];
    logic [31:0]         data_q  [2][NUM_SETS][BLOCK_WORDS];
    logic [NUM_SETS-1:0] lru_q;
    logic [OffW-1:0]     cnt_q;
    logic [IdxW-1:0]     fill_idx_q;
    logic [TagW-1:0]     fill_tag_q;
    logic                victim_q;
    logic [31:0]         mem_addr_q;
    logic                mem_req_q;

    logic [IdxW-1:0] idx;
    logic [OffW-1:0] off;
    logic [TagW-1:0] tag;
    logic            hit0;
    logic            hit1;
    logic            hit;
    logic            hit_way;
    logic            victim;
    logic            lookup_hit;

    always_comb begin
        idx     = bus.read_address[OffW+2 +: IdxW];
        off     = bus.read_address[2 +: OffW];
        tag     = bus.read_address[31 -: TagW];
        hit0    = valid_q[0][idx] && (tag_q[0][idx] == tag);
        hit1    = valid_q[1][idx] && (tag_q[1][idx] == tag);
        hit     = hit0 || hit1;
        hit_way = hit1;
        // Fill empty ways first; only fall back to LRU once the set is full.
        if (!valid_q[0][idx]) begin
            victim = 1'b0;
        end else if (!valid_q[1][idx]) begin
            victim = 1'b1;
        end else begin
            victim = lru_q[idx];
        end
        lookup_hit = !reset && (state_q == StIdle) && hit;
    end

    assign bus.ready            = !reset && (!bus.read_enable || lookup_hit);
    assign bus.instruction      = lookup_hit ? data_q[hit_way][idx][off] : Nop;
    assign bus.mem_read_address = mem_addr_q;
    assign bus.mem_read_request = mem_req_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            lru_q      <= '0;
            cnt_q      <= '0;
            fill_idx_q <= '0;
            fill_tag_q <= '0;
            victim_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.read_enable) begin
                        if (hit) begin
                            lru_q[idx] <= ~hit_way;
                        end else begin
                            mem_addr_q <= {bus.read_address[31:OffW+2], {(OffW+2){1'b0}}};
                            fill_idx_q <= idx;
                            fill_tag_q <= tag;
                            victim_q   <= victim;
                            mem_req_q  <= 1'b1;
                            state_q    <= StReq;
                        end
                    end
                end
                StReq: begin
                    mem_req_q <= 1'b0;
                    state_q   <= StFill;
                end
                StFill: begin
                    if (bus.mem_data_ready) begin
                        data_q[victim_q][fill_idx_q][cnt_q] <= bus.mem_data_in;
                        if (cnt_q == OffW'(BLOCK_WORDS - 1)) begin
                            valid_q[victim_q][fill_idx_q] <= 1'b1;
                            tag_q[victim_q][fill_idx_q]   <= fill_tag_q;
                            lru_q[fill_idx_q]             <= ~victim_q;
                            cnt_q                         <= '0;
                            state_q                       <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ucsbece154b_icache.sv
// Self-checking bench: directed cache scenarios followed by random accesses,
// compared against a block-address level model of a 2-way LRU cache.
module tb_ucsbece154b_icache;

    localparam int unsigned NumSets    = 8;
    localparam int unsigned BlockWords = 4;
    localparam int unsigned BlockBytes = BlockWords * 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    ucsbece154b_icache_if bus ();

    ucsbece154b_icache #(
        .NUM_SETS    (NumSets),
        .BLOCK_WORDS (BlockWords)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Static memory image; first block holds the directed 0x11..0x44 words.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w < 32'h10) return (32'(w[3:2]) + 32'd1) * 32'h11;
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Request monitor.
    int          req_cnt   = 0;
    int          pulse_bad = 0;
    logic [31:0] req_addr  = '0;
    bit          prev_req  = 1'b0;
    always @(posedge clk) begin
        if (!reset && bus.mem_read_request) begin
            req_cnt++;
            req_addr = bus.mem_read_address;
            if (prev_req) pulse_bad++;
        end
        prev_req = !reset && bus.mem_read_request;
    end

    // Burst memory: first word the cycle after the request, then one word
    // every gap+1 cycles; reset drops the burst.
    int          gap         = 0;
    bit          force_ready = 1'b0;
    bit          busy        = 1'b0;
    logic [31:0] base        = '0;
    int          k           = 0;
    int          wait_cnt    = 0;
    always @(posedge clk) begin
        if (reset) begin
            busy               <= 1'b0;
            bus.mem_data_ready <= 1'b0;
            bus.mem_data_in    <= '0;
        end else if (bus.mem_read_request) begin
            busy               <= 1'b1;
            base               <= bus.mem_read_address;
            k                  <= 1;
            wait_cnt           <= gap;
            bus.mem_data_ready <= 1'b1;
            bus.mem_data_in    <= mem_word(bus.mem_read_address);
        end else if (busy && wait_cnt == 0) begin
            bus.mem_data_ready <= 1'b1;
            bus.mem_data_in    <= mem_word(base + 32'(4 * k));
            k                  <= k + 1;
            wait_cnt           <= gap;
            if (k == BlockWords - 1) busy <= 1'b0;
        end else begin
            if (busy) wait_cnt <= wait_cnt - 1;
            bus.mem_data_ready <= force_ready;
            bus.mem_data_in    <= 32'hDEAD_BEEF;
        end
    end

    // Reference model: each set holds up to two block numbers plus the way to evict next.
    bit          mv   [2][NumSets];
    logic [31:0] mblk [2][NumSets];
    bit          ml   [NumSets];

    function automatic void m_reset();
        for (int s = 0; s < NumSets; s++) begin
            mv[0][s] = 1'b0;
            mv[1][s] = 1'b0;
            ml[s]    = 1'b0;
        end
    endfunction

    function automatic int m_lookup(input logic [31:0] a);
        logic [31:0] blk;
        int          s;
        blk = a / BlockBytes;
        s   = int'(blk % NumSets);
        for (int w = 0; w < 2; w++) if (mv[w][s] && mblk[w][s] == blk) return w;
        return -1;
    endfunction

    function automatic void m_touch(input logic [31:0] a, input int w);
        ml[int'((a / BlockBytes) % NumSets)] = (w == 0);
    endfunction

    function automatic void m_install(input logic [31:0] a);
        logic [31:0] blk;
        int          s;
        int          w;
        blk = a / BlockBytes;
        s   = int'(blk % NumSets);
        if (!mv[0][s])      w = 0;
        else if (!mv[1][s]) w = 1;
        else                w = ml[s] ? 1 : 0;
        mv[w][s]   = 1'b1;
        mblk[w][s] = blk;
        ml[s]      = (w == 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One fetch at address a; on a miss, waits out the refill and checks it.
    task automatic access(input logic [31:0] a, input int g, output bit was_hit);
        int w;
        int n;
        int r0;
        @(negedge clk);
        gap              = g;
        bus.read_enable  = 1'b1;
        bus.read_address = a;
        #1;
        w       = m_lookup(a);
        was_hit = bus.ready;
        chk("lookup_ready", 32'(bus.ready), (w >= 0) ? 32'd1 : 32'd0);
        if (w >= 0) begin
            chk("hit_data", bus.instruction, mem_word(a));
            m_touch(a, w);
        end else begin
            r0 = req_cnt;
            n  = 0;
            while (!bus.ready && n < 200) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("refill_done", 32'(bus.ready), 32'd1);
            chk("req_count", 32'(req_cnt - r0), 32'd1);
            chk("req_addr", req_addr, a & ~(BlockBytes - 1));
            chk("refill_latency", 32'(n), 32'(2 + BlockWords + (BlockWords - 1) * g));
            m_install(a);
            chk("refill_data", bus.instruction, mem_word(a));
            m_touch(a, m_lookup(a));
        end
    endtask

    task automatic idle_step(input logic [31:0] a);
        @(negedge clk);
        bus.read_enable  = 1'b0;
        bus.read_address = a;
        #1;
        chk("idle_ready", 32'(bus.ready), 32'd1);
    endtask

    initial begin
        bit          h;
        int          r0;
        int          n;
        int          bad;
        logic [31:0] a;

        bus.read_enable  = 1'b1;
        bus.read_address = '0;
        m_reset();

        // Reset-cycle outputs.
        @(negedge clk);
        #1;
        chk("reset_ready", 32'(bus.ready), 32'd0);
        chk("reset_instr", bus.instruction, 32'h0000_0013);
        chk("reset_req", 32'(bus.mem_read_request), 32'd0);
        chk("reset_mem_addr", bus.mem_read_address, 32'd0);
        bus.read_enable = 1'b0;
        #1;
        chk("reset_ready_noreq", 32'(bus.ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Cold miss on 0x0.
        access(32'h0, 0, h);
        chk("t1_cold_miss", 32'(h), 32'd0);
        chk("t1_word0", bus.instruction, 32'h11);
        chk("t1_req_addr", req_addr, 32'h0);

        // Spatial hits.
        r0 = req_cnt;
        access(32'h4, 0, h);
        chk("t2_word1", bus.instruction, 32'h22);
        access(32'h8, 0, h);
        chk("t2_word2", bus.instruction, 32'h33);
        access(32'hC, 0, h);
        chk("t2_word3", bus.instruction, 32'h44);
        chk("t2_no_req", 32'(req_cnt - r0), 32'd0);
        chk("t2_addr_held", bus.mem_read_address, 32'h0);

        // Conflict and LRU replacement in set 0.
        access(32'h080, 0, h);
        chk("t3_080_miss", 32'(h), 32'd0);
        access(32'h000, 0, h);
        chk("t3_000_hit", 32'(h), 32'd1);
        access(32'h100, 0, h);
        chk("t3_100_miss", 32'(h), 32'd0);
        access(32'h000, 0, h);
        chk("t3_000_still_hit", 32'(h), 32'd1);
        access(32'h080, 0, h);
        chk("t3_080_evicted", 32'(h), 32'd0);

        // Redirect during refill.
        @(negedge clk);
        gap              = 0;
        bus.read_enable  = 1'b1;
        bus.read_address = 32'h40;
        #1;
        chk("t4_miss_ready", 32'(bus.ready), 32'd0);
        r0 = req_cnt;
        @(negedge clk);
        #1;
        chk("t4_req_ready", 32'(bus.ready), 32'd0);
        @(negedge clk);
        bus.read_address = 32'h200;
        #1;
        chk("t4_fill_ready", 32'(bus.ready), 32'd0);
        n   = 0;
        bad = 0;
        while (req_cnt < r0 + 2 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
            if (bus.ready) bad++;
        end
        chk("t4_second_req", 32'(req_cnt - r0), 32'd2);
        chk("t4_redirect_timing", 32'(n), 32'd6);
        chk("t4_no_ready", 32'(bad), 32'd0);
        chk("t4_req_addr", req_addr, 32'h200);
        m_install(32'h40);
        n = 0;
        while (!bus.ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t4_200_done", 32'(bus.ready), 32'd1);
        m_install(32'h200);
        chk("t4_200_data", bus.instruction, mem_word(32'h200));
        m_touch(32'h200, m_lookup(32'h200));
        access(32'h44, 0, h);
        chk("t4_40_installed", 32'(h), 32'd1);

        // Gapped memory.
        access(32'h500, 1, h);
        chk("t5_gapped_miss", 32'(h), 32'd0);
        access(32'h504, 0, h);
        access(32'h508, 0, h);
        access(32'h50C, 0, h);
        chk("t5_word3", bus.instruction, mem_word(32'h50C));

        // Reset mid-fill after two words, then spurious data in IDLE.
        @(negedge clk);
        gap              = 0;
        bus.read_enable  = 1'b1;
        bus.read_address = 32'h600;
        #1;
        chk("t6_miss_ready", 32'(bus.ready), 32'd0);
        repeat (4) @(negedge clk);
        reset           = 1'b1;
        bus.read_enable = 1'b0;
        @(negedge clk);
        reset       = 1'b0;
        force_ready = 1'b1;
        m_reset();
        repeat (3) idle_step(32'h600);
        force_ready = 1'b0;
        idle_step(32'h600);
        idle_step(32'h600);
        r0 = req_cnt;
        access(32'h600, 0, h);
        chk("t6_refetch_miss", 32'(h), 32'd0);
        chk("t6_new_req", 32'(req_cnt - r0), 32'd1);
        access(32'h000, 0, h);
        chk("t6_cache_cleared", 32'(h), 32'd0);

        // Random traffic over a few conflicting sets.
        for (int i = 0; i < 40; i++) begin
            a = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 1)) << 4)
              | (32'($urandom_range(0, 3)) << 2);
            if ($urandom_range(0, 4) == 0) idle_step(a);
            else access(a, int'($urandom_range(0, 2)), h);
        end

        chk("req_pulse_width", 32'(pulse_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
